vga_fb_write_arbiter: RTL
=========================

// Module: vga_fb_write_arbiter
// PURPOSE
//  Owns the single write port of the VGA frame-buffer (pixel index RAM read by the VGA controller).
//  Shares that port between two requesters: 0 = CPU store path, 1 = game drawing engine.
//  Arbitration is round-robin.
//  Adds a built-in clear sequencer that fills the whole buffer with one colour index.
//  Sits between the processor/game logic and the frame-buffer RAM, in the iVGA_CLK domain.
// PARAMETERS
//  ADDR_W    19      frame-buffer address width
//  DATA_W    8       colour index width
//  FB_DEPTH  307200  pixels swept by a clear (640x480); must be <= 2**ADDR_W
// PORTS
//  iVGA_CLK    in   1       sole clock; all state changes on its rising edge
//  iRST_n      in   1       asynchronous reset, active low
//  iVBLANK     in   1       1 while the sync generator is in vertical blanking
//  iREQ0       in   1       requester 0 write request, held until granted
//  iADDR0      in   ADDR_W  requester 0 write address
//  iDATA0      in   DATA_W  requester 0 write data
//  oGNT0       out  1       1-cycle pulse: requester 0 write issued this cycle
//  iREQ1, iADDR1, iDATA1, oGNT1    same as above, for requester 1
//  iCLR_START  in   1       pulse: start a full-buffer clear
//  iCLR_DATA   in   DATA_W  fill colour, sampled with iCLR_START
//  oCLR_BUSY   out  1       1 while the clear sweep is running
//  oWE         out  1       frame-buffer write enable
//  oWADDR      out  ADDR_W  frame-buffer write address
//  oWDATA      out  DATA_W  frame-buffer write data
// BEHAVIOUR
//  - Reset (async, iRST_n=0):
//    - all outputs 0
//    - state=IDLE, sweep counter=0
//    - rr pointer=1, so requester 0 wins the first tie
//  - All outputs are registered. oWE/oWADDR/oWDATA/oGNTk update on the same edge.
//    A write is performed exactly in a cycle where oWE=1.
//  - State IDLE, evaluated each edge:
//    - eligible_k = iREQk & ~oGNTk. The cycle after a grant masks that requester, so it can drop or update its request.
//    - If iCLR_START=1:
//      - state<=CLEAR, counter<=0, fill<=iCLR_DATA, oCLR_BUSY<=1
//      - oWE<=0, no grant, even if requests are pending
//    - Else, if one requester is eligible: grant it.
//    - If both are eligible: grant the requester != rr pointer.
//    - On a grant:
//      - oGNTk<=1, oWE<=1, oWADDR<=iADDRk, oWDATA<=iDATAk
//      - rr pointer<=k
//    - If neither is eligible: oWE<=0, oGNT0/1<=0.
//  - State CLEAR:
//    - Each edge: oWE<=1, oWADDR<=counter, oWDATA<=fill, counter<=counter+1.
//    - No grants in CLEAR; requests stay pending, and requesters keep iREQ/iADDR/iDATA stable.
//    - When counter==FB_DEPTH-1 is issued: state<=IDLE, oCLR_BUSY<=0, counter<=0.
//    - iCLR_START is ignored during CLEAR; fill and counter are unchanged.
//    - Throughput: exactly FB_DEPTH consecutive writes. oCLR_BUSY high for FB_DEPTH cycles.
//  - Latency: request to write is 1 cycle if IDLE and uncontested; pending requests resume the cycle after oCLR_BUSY falls.
//  - Address width: counter is ADDR_W bits and never wraps (stops at FB_DEPTH-1).
//    Requester addresses pass through unchecked.
//  - Reset mid-clear: sweep aborted immediately, outputs 0, state=IDLE. The partially cleared buffer is left as-is.
// CONFIGURATION
//  VBLANK_ONLY_EN defined:
//    - Requester grants are issued only while iVBLANK=1.
//    - In CLEAR, the sweep advances only while iVBLANK=1.
//    - While iVBLANK=0: oWE=0, counter holds, oCLR_BUSY stays 1.
//    - The clear therefore spans multiple frames.
//    - Prevents tearing.
//  VBLANK_ONLY_EN undefined:
//    - iVBLANK is ignored.
//    - Writes are issued at any time, as described above.
// TESTING  (use FB_DEPTH=16)
//  1. Reset asserted mid-traffic -> all outputs 0 asynchronously.
//     First tie after release -> oGNT0.
//  2. iREQ0=1, ADDR0=0x00123, DATA0=0x5A, alone -> next cycle:
//     oWE=1, oWADDR=0x00123, oWDATA=0x5A, oGNT0=1.
//     Held request -> next grant two cycles later.
//  3. iREQ0=iREQ1=1 held continuously -> grants alternate 0,1,0,1; oWE=1 every cycle.
//  4. iCLR_START=1, iCLR_DATA=0x07 with iREQ1 pending:
//     - oCLR_BUSY=1 for 16 cycles; oWADDR=0..15 with data 0x07
//     - then oGNT1 the cycle after oCLR_BUSY falls
//  5. Second iCLR_START at sweep address 5 -> ignored; sweep ends at 15.
//     iRST_n=0 at address 9 -> oWE=0 and oCLR_BUSY=0 immediately.
//  6. (VBLANK_ONLY_EN) iVBLANK=0, iREQ0=1 -> no grant.
//     iVBLANK rises -> oGNT0 next edge.
//     Clear with iVBLANK toggling -> counter holds while iVBLANK is low; 16 writes total.

Source files
------------

// File: rtl/vga_fb_write_arbiter.sv
// Frame-buffer write-port owner: round-robin between CPU (0) and draw engine (1), plus a full-buffer clear sweep.
// Optional build macro VBLANK_ONLY_EN restricts all writes to vertical blanking.
module vga_fb_write_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_DEPTH = 307200
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVBLANK,
  input  logic              iREQ0,
  input  logic [ADDR_W-1:0] iADDR0,
  input  logic [DATA_W-1:0] iDATA0,
  output logic              oGNT0,
  input  logic              iREQ1,
  input  logic [ADDR_W-1:0] iADDR1,
  input  logic [DATA_W-1:0] iDATA1,
  output logic              oGNT1,
  input  logic              iCLR_START,
  input  logic [DATA_W-1:0] iCLR_DATA,
  output logic              oCLR_BUSY,
  output logic              oWE,
  output logic [ADDR_W-1:0] oWADDR,
  output logic [DATA_W-1:0] oWDATA
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                rr_q, rr_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_ok;
  logic                elig0, elig1;

`ifdef VBLANK_ONLY_EN
  assign write_ok = iVBLANK;
`else
  logic unused_vblank;
  assign unused_vblank = iVBLANK;
  assign write_ok      = 1'b1;
`endif

  // A requester granted last cycle is masked so it can drop or change its request.
  assign elig0 = iREQ0 & ~gnt0_q;
  assign elig1 = iREQ1 & ~gnt1_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      rr_q    <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    we_d    = 1'b0;
    busy_d  = busy_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (iCLR_START) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          fill_d  = iCLR_DATA;
          busy_d  = 1'b1;
        end else if (write_ok) begin
          // On a tie the requester that did not win last time goes first.
          if (elig0 && (!elig1 || rr_q)) begin
            gnt0_d  = 1'b1;
            we_d    = 1'b1;
            waddr_d = iADDR0;
            wdata_d = iDATA0;
            rr_d    = 1'b0;
          end else if (elig1) begin
            gnt1_d  = 1'b1;
            we_d    = 1'b1;
            waddr_d = iADDR1;
            wdata_d = iDATA1;
            rr_d    = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (write_ok) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = fill_q;
          if (cnt_q == LAST_ADDR) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oGNT0     = gnt0_q;
  assign oGNT1     = gnt1_q;
  assign oWE       = we_q;
  assign oCLR_BUSY = busy_q;
  assign oWADDR    = waddr_q;
  assign oWDATA    = wdata_q;

endmodule
